// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run-control and state-dump engine for simple_cpu
//
// Purpose: holds simple_cpu in reset, releases it, and stops it on a cycle
// budget or a PC-stall halt. It then streams every register-file word and
// every data-memory word to a trace sink over a valid/ready port.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               1-cycle pulse, begins a run from IDLE or DONE
//   pc                  CPU program counter, watched for stalls
//   cpu_rstn            active-low reset to simple_cpu (high only in RUN)
//   dbg_sel, dbg_addr   debug read select (0 regfile, 1 dmem) and index
//   dbg_rdata           combinational debug read data
//   dump_valid/ready    dump beat handshake
//   dump_sel/idx/data   current dump beat contents
//   run_cycles          cycles spent in RUN (saturating)
//   halt_cause          0 none, 1 PC stall, 2 budget exhausted
//   done                high in DONE
module cpu_run_ctrl #(
    parameter int XLEN         = 32,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 94,
    parameter int STALL_LIMIT  = 4,
    parameter int NUM_REGS     = 32,
    parameter int MEM_WORDS    = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] pc,
    output logic            cpu_rstn,
    output logic            dbg_sel,
    output logic [15:0]     dbg_addr,
    input  logic [XLEN-1:0] dbg_rdata,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic            dump_sel,
    output logic [15:0]     dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic [31:0]     run_cycles,
    output logic [1:0]      halt_cause,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DUMP_REG,
        S_DUMP_MEM,
        S_DONE
    } state_t;

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

    localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_CYCLES - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);
    localparam logic [15:0]   REG_LAST   = 16'(NUM_REGS - 1);
    localparam logic [15:0]   MEM_LAST   = 16'(MEM_WORDS - 1);
    localparam logic [31:0]   BUDGET     = 32'(MAX_CYCLES);

    state_t            state_q, state_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [SW-1:0]     stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [15:0]       idx_q, idx_d;
    logic [31:0]       run_cycles_q, run_cycles_d;
    logic [1:0]        halt_cause_q, halt_cause_d;
    logic              stall_hit;
    logic              budget_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            pc_q         <= '0;
            idx_q        <= '0;
            run_cycles_q <= '0;
            halt_cause_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            run_cycles_q <= run_cycles_d;
            halt_cause_q <= halt_cause_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        pc_d         = pc;
        idx_d        = idx_q;
        run_cycles_d = run_cycles_q;
        halt_cause_d = halt_cause_q;
        stall_hit    = 1'b0;
        budget_hit   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_HOLD;
                    hold_cnt_d   = '0;
                    stall_cnt_d  = '0;
                    idx_d        = '0;
                    run_cycles_d = '0;
                    halt_cause_d = 2'd0;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (run_cycles_q != 32'hFFFF_FFFF) begin
                    run_cycles_d = run_cycles_q + 32'd1;
                end
                // run_cycles_q is zero only in the first RUN cycle, where pc_q
                // still holds a pre-run value, so that cycle counts as a change.
                if (run_cycles_q == 32'd0 || pc != pc_q) begin
                    stall_cnt_d = '0;
                end else begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
                stall_hit  = (stall_cnt_d == STALL_LAST);
                budget_hit = (run_cycles_d >= BUDGET);
                if (stall_hit || budget_hit) begin
                    state_d      = S_DUMP_REG;
                    idx_d        = '0;
                    halt_cause_d = stall_hit ? 2'd1 : 2'd2;
                end
            end
            S_DUMP_REG: begin
                if (dump_ready) begin
                    if (idx_q == REG_LAST) begin
                        state_d = S_DUMP_MEM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            S_DUMP_MEM: begin
                if (dump_ready) begin
                    if (idx_q == MEM_LAST) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cpu_rstn   = (state_q == S_RUN);
    assign dump_valid = (state_q == S_DUMP_REG) || (state_q == S_DUMP_MEM);
    assign dbg_sel    = (state_q == S_DUMP_MEM);
    assign dbg_addr   = idx_q;
    assign dump_sel   = dbg_sel;
    assign dump_idx   = idx_q;
    assign dump_data  = dbg_rdata;
    assign run_cycles = run_cycles_q;
    assign halt_cause = halt_cause_q;
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pc = '0;
    logic        cpu_rstn, dbg_sel, dump_valid, dump_sel, done;
    logic        dump_ready = 1'b0;
    logic [15:0] dbg_addr, dump_idx;
    logic [31:0] dbg_rdata, dump_data, run_cycles;
    logic [1:0]  halt_cause;

    logic        start2 = 1'b0;
    logic [31:0] pc2 = '0;
    logic        cpu_rstn2, dbg_sel2, dump_valid2, dump_sel2, done2;
    logic [15:0] dbg_addr2, dump_idx2;
    logic [31:0] dbg_rdata2, dump_data2, run_cycles2;
    logic [1:0]  halt_cause2;

    logic [31:0] salt = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct packed {
        logic        sel;
        logic [15:0] idx;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];

    function automatic logic [31:0] mem_model(input logic sel, input logic [15:0] addr,
                                              input logic [31:0] s);
        return {(sel ? 8'hD0 : 8'hA0), 8'h00, addr} ^ s;
    endfunction

    assign dbg_rdata  = mem_model(dbg_sel, dbg_addr, salt);
    assign dbg_rdata2 = mem_model(dbg_sel2, dbg_addr2, 32'h0);

    cpu_run_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .cpu_rstn(cpu_rstn),
        .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_sel(dump_sel),
        .dump_idx(dump_idx), .dump_data(dump_data), .run_cycles(run_cycles),
        .halt_cause(halt_cause), .done(done)
    );

    cpu_run_ctrl #(.MAX_CYCLES(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .pc(pc2), .cpu_rstn(cpu_rstn2),
        .dbg_sel(dbg_sel2), .dbg_addr(dbg_addr2), .dbg_rdata(dbg_rdata2),
        .dump_valid(dump_valid2), .dump_ready(1'b1), .dump_sel(dump_sel2),
        .dump_idx(dump_idx2), .dump_data(dump_data2), .run_cycles(run_cycles2),
        .halt_cause(halt_cause2), .done(done2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_rstn"}, cpu_rstn, 0);
        check({tag, "_dump_valid"}, dump_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_run_cycles"}, run_cycles, 0);
        check({tag, "_halt_cause"}, halt_cause, 0);
        check({tag, "_dbg_sel"}, dbg_sel, 0);
        check({tag, "_dbg_addr"}, dbg_addr, 0);
    endtask

    // One full run on the main instance. stall_k=0 keeps pc moving every
    // cycle; otherwise pc freezes from RUN cycle stall_k. rmode=1 randomises
    // dump_ready. abort=1 asserts rst at DUMP_MEM index 50.
    task automatic do_run(input int stall_k, input int exp_rc, input int exp_cause,
                          input int rmode, input int abort);
        int    lowcnt;
        int    k;
        int    cyc;
        bit    prev_pend;
        bit    stop;
        beat_t prev;
        beat_t e;

        salt = $urandom;
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back({1'b0, 16'(i), mem_model(1'b0, 16'(i), salt)});
        for (int i = 0; i < 128; i++) exp_q.push_back({1'b1, 16'(i), mem_model(1'b1, 16'(i), salt)});

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_done_cleared", done, 0);
        lowcnt = 0;
        while (!cpu_rstn && lowcnt < 20) begin
            lowcnt++;
            @(negedge clk);
        end
        check("hold_cycles", lowcnt, 2);

        k = 1;
        while (cpu_rstn && k < 300) begin
            pc = 32'h18 + 32'(4 * ((stall_k != 0 && k > stall_k) ? stall_k : k));
            start = (k == 3);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("run_len", k - 1, exp_rc);
        check("run_cycles", run_cycles, exp_rc);
        check("halt_cause", halt_cause, exp_cause);

        cyc = 0;
        prev_pend = 1'b0;
        prev = '0;
        stop = 1'b0;
        while (exp_q.size() > 0 && cyc < 4000 && !stop) begin
            if (prev_pend) begin
                check("stall_hold_sel", dump_sel, prev.sel);
                check("stall_hold_idx", dump_idx, prev.idx);
                check("stall_hold_data", dump_data, prev.data);
            end
            if (abort != 0 && dump_sel && dump_idx == 16'd50) begin
                rst = 1'b1;
                dump_ready = 1'b0;
                @(negedge clk);
                check_reset_outputs("abort");
                rst = 1'b0;
                exp_q.delete();
                stop = 1'b1;
            end else begin
                check("dump_valid_high", dump_valid, 1);
                dump_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (dump_valid && dump_ready) begin
                    e = exp_q.pop_front();
                    check("beat_sel", dump_sel, e.sel);
                    check("beat_idx", dump_idx, e.idx);
                    check("beat_data", dump_data, e.data);
                    prev_pend = 1'b0;
                end else begin
                    prev_pend = dump_valid;
                    prev = {dump_sel, dump_idx, dump_data};
                end
                cyc++;
                @(negedge clk);
            end
        end
        dump_ready = 1'b0;

        if (abort != 0) begin
            check("abort_reached", stop, 1);
        end else begin
            check("beats_left", exp_q.size(), 0);
            check("done_after_dump", done, 1);
            check("valid_low_done", dump_valid, 0);
            check("cpu_rstn_done", cpu_rstn, 0);
            check("run_cycles_held", run_cycles, exp_rc);
            check("halt_cause_held", halt_cause, exp_cause);
            if (rmode == 0) check("dump_cycles", cyc, 160);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int k;
        int w;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        check("reset2_cpu_rstn", cpu_rstn2, 0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        do_run(0, 94, 2, 0, 0);
        do_run(10, 13, 1, 1, 0);

        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        w = 0;
        while (!cpu_rstn2 && w < 20) begin
            w++;
            @(negedge clk);
        end
        k = 1;
        while (cpu_rstn2 && k < 100) begin
            pc2 = 32'h100 + 32'(4 * ((k > 5) ? 5 : k));
            @(negedge clk);
            k++;
        end
        check("tie_halt_cause", halt_cause2, 1);
        check("tie_run_cycles", run_cycles2, 8);
        w = 0;
        while (!done2 && w < 400) begin
            w++;
            @(negedge clk);
        end
        check("tie_done", done2, 1);

        do_run(0, 94, 2, 0, 1);
        do_run(10, 13, 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
